// File: rtl/alarm_ring_multi.sv
`default_nettype none
// alarm_ring_multi: N-channel BCD alarm matcher with lowest-index-first service,
// snooze/auto-snooze ringing, sticky missed flags and a minigame handshake.
module alarm_ring_multi #(
  parameter int N_ALARMS         = 4,
  parameter int SNOOZE_SEC       = 5,
  parameter int RING_TIMEOUT_SEC = 30,
  parameter int MAX_SNOOZE       = 3,
  parameter int IDW              = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                   MCLK,
  input  logic                   RESET_N,
  input  logic                   sec_tick,
  input  logic [15:0]            cur_time,
  input  logic [16*N_ALARMS-1:0] alarm_time,
  input  logic [N_ALARMS-1:0]    ch_enable,
  input  logic                   btn_dismiss,
  input  logic                   btn_snooze,
  input  logic                   minigame_done,
  input  logic                   clear_missed,
  output logic                   alarm_ringing,
  output logic                   snoozing,
  output logic                   minigame_enable,
  output logic [IDW-1:0]         ring_id,
  output logic [N_ALARMS-1:0]    pending,
  output logic [N_ALARMS-1:0]    missed
);

  localparam int RTW = $clog2(RING_TIMEOUT_SEC + 1);
  localparam int STW = $clog2(SNOOZE_SEC + 1);
  localparam int SCW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  localparam logic [RTW-1:0] RING_LAST = RTW'(RING_TIMEOUT_SEC - 1);
  localparam logic [STW-1:0] SNZ_LOAD  = STW'(SNOOZE_SEC);
  localparam logic [SCW-1:0] SNZ_MAX   = SCW'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RING   = 2'd1,
    S_SNOOZE = 2'd2,
    S_GAME   = 2'd3
  } state_e;

  state_e              state_q;
  logic [N_ALARMS-1:0] match_d, match_q;
  logic [N_ALARMS-1:0] pending_d, pending_q;
  logic [N_ALARMS-1:0] missed_q;
  logic [N_ALARMS-1:0] serve_mask_d, id_mask_d;
  logic [IDW-1:0]      ring_id_q, first_idx_d;
  logic [RTW-1:0]      ring_timer_q;
  logic [STW-1:0]      snooze_timer_q;
  logic [SCW-1:0]      snooze_cnt_q;
  logic                ringing_q, snoozing_q, game_q;
  logic                cur_en_d, serve_d, tmo_d, can_snz_d;

  always_comb begin
    match_d      = '0;
    id_mask_d    = '0;
    serve_mask_d = '0;
    first_idx_d  = '0;
    cur_en_d     = 1'b0;
    for (int i = 0; i < N_ALARMS; i++) begin
      match_d[i] = ch_enable[i] && (cur_time == alarm_time[16*i +: 16]);
      if (IDW'(i) == ring_id_q) begin
        id_mask_d[i] = 1'b1;
        cur_en_d     = ch_enable[i];
      end
    end
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (pending_q[i]) first_idx_d = IDW'(i);
    end
    serve_d = (state_q == S_IDLE) && (|pending_q);
    for (int i = 0; i < N_ALARMS; i++) begin
      serve_mask_d[i] = serve_d && (IDW'(i) == first_idx_d);
    end
    // New rising matches on other channels survive the serve-clear of this cycle.
    pending_d = (pending_q | (match_d & ~match_q)) & ch_enable & ~serve_mask_d;
    tmo_d     = sec_tick && (ring_timer_q == RING_LAST);
    can_snz_d = (snooze_cnt_q < SNZ_MAX);
  end

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q        <= S_IDLE;
      match_q        <= '1;
      pending_q      <= '0;
      missed_q       <= '0;
      ring_id_q      <= '0;
      ring_timer_q   <= '0;
      snooze_timer_q <= '0;
      snooze_cnt_q   <= '0;
      ringing_q      <= 1'b0;
      snoozing_q     <= 1'b0;
      game_q         <= 1'b0;
    end else begin
      match_q   <= match_d;
      pending_q <= pending_d;
      if (clear_missed) missed_q <= '0;

      unique case (state_q)
        S_IDLE: begin
          if (|pending_q) begin
            state_q      <= S_RING;
            ringing_q    <= 1'b1;
            ring_id_q    <= first_idx_d;
            ring_timer_q <= '0;
            snooze_cnt_q <= '0;
          end
        end
        S_RING: begin
          if (!cur_en_d) begin
            state_q   <= S_IDLE;
            ringing_q <= 1'b0;
          end else if (btn_dismiss) begin
            state_q   <= S_GAME;
            ringing_q <= 1'b0;
            game_q    <= 1'b1;
          end else if ((btn_snooze || tmo_d) && can_snz_d) begin
            state_q        <= S_SNOOZE;
            ringing_q      <= 1'b0;
            snoozing_q     <= 1'b1;
            snooze_cnt_q   <= snooze_cnt_q + 1'b1;
            snooze_timer_q <= SNZ_LOAD;
          end else if (tmo_d) begin
            state_q   <= S_IDLE;
            ringing_q <= 1'b0;
            missed_q  <= (clear_missed ? '0 : missed_q) | id_mask_d;
          end else if (sec_tick) begin
            ring_timer_q <= ring_timer_q + 1'b1;
          end
        end
        S_SNOOZE: begin
          if (!cur_en_d) begin
            state_q    <= S_IDLE;
            snoozing_q <= 1'b0;
          end else if (btn_dismiss) begin
            state_q    <= S_GAME;
            snoozing_q <= 1'b0;
            game_q     <= 1'b1;
          end else if (sec_tick) begin
            if (snooze_timer_q == STW'(1)) begin
              state_q      <= S_RING;
              snoozing_q   <= 1'b0;
              ringing_q    <= 1'b1;
              ring_timer_q <= '0;
            end else begin
              snooze_timer_q <= snooze_timer_q - 1'b1;
            end
          end
        end
        S_GAME: begin
          if (minigame_done) begin
            state_q <= S_IDLE;
            game_q  <= 1'b0;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          ringing_q  <= 1'b0;
          snoozing_q <= 1'b0;
          game_q     <= 1'b0;
        end
      endcase
    end
  end

  assign alarm_ringing   = ringing_q;
  assign snoozing        = snoozing_q;
  assign minigame_enable = game_q;
  assign ring_id         = ring_id_q;
  assign pending         = pending_q;
  assign missed          = missed_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_ring_multi.sv
`default_nettype none
// Bench for alarm_ring_multi: directed scenarios with literal spot checks, plus a
// per-cycle reference model of the alarm rules compared on every falling edge.
module tb_alarm_ring_multi;

  localparam int N    = 4;
  localparam int SNZ  = 5;
  localparam int TMO  = 30;
  localparam int MAXS = 3;
  localparam int IDW  = 2;

  localparam int MD_IDLE   = 0;
  localparam int MD_RING   = 1;
  localparam int MD_SNOOZE = 2;
  localparam int MD_GAME   = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            sec_tick = 1'b0;
  logic [15:0]     cur_time = 16'h0005;
  logic [16*N-1:0] alarm_time = {16'h0059, 16'h0020, 16'h0010, 16'h0005};
  logic [N-1:0]    ch_enable = 4'hF;
  logic            btn_dismiss = 1'b0;
  logic            btn_snooze = 1'b0;
  logic            minigame_done = 1'b0;
  logic            clear_missed = 1'b0;
  logic            alarm_ringing, snoozing, minigame_enable;
  logic [IDW-1:0]  ring_id;
  logic [N-1:0]    pending, missed;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, in plain integers.
  int           mode = MD_IDLE;
  int           m_id = 0;
  int           m_elapsed = 0;
  int           m_left = 0;
  int           m_used = 0;
  logic [N-1:0] m_pending = '0;
  logic [N-1:0] m_missed = '0;
  logic [N-1:0] m_prev = '1;

  alarm_ring_multi #(
    .N_ALARMS(N), .SNOOZE_SEC(SNZ), .RING_TIMEOUT_SEC(TMO), .MAX_SNOOZE(MAXS)
  ) dut (
    .MCLK(clk), .RESET_N(rst_n), .sec_tick(sec_tick), .cur_time(cur_time),
    .alarm_time(alarm_time), .ch_enable(ch_enable), .btn_dismiss(btn_dismiss),
    .btn_snooze(btn_snooze), .minigame_done(minigame_done), .clear_missed(clear_missed),
    .alarm_ringing(alarm_ringing), .snoozing(snoozing), .minigame_enable(minigame_enable),
    .ring_id(ring_id), .pending(pending), .missed(missed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic model_reset();
    mode = MD_IDLE; m_id = 0; m_elapsed = 0; m_left = 0; m_used = 0;
    m_pending = '0; m_missed = '0; m_prev = '1;
  endtask

  task automatic begin_snooze();
    mode = MD_SNOOZE;
    m_used++;
    m_left = SNZ;
  endtask

  // Applies the alarm rules to the inputs the DUT will sample at the next rising edge.
  task automatic model_advance();
    logic [N-1:0] now_match, served, nmissed;
    now_match = '0;
    served    = '0;
    for (int i = 0; i < N; i++)
      now_match[i] = ch_enable[i] && (cur_time == alarm_time[16*i +: 16]);
    nmissed = clear_missed ? '0 : m_missed;
    case (mode)
      MD_IDLE: begin
        if (m_pending != 0) begin
          for (int i = N - 1; i >= 0; i--) if (m_pending[i]) m_id = i;
          served[m_id] = 1'b1;
          mode = MD_RING; m_elapsed = 0; m_used = 0;
        end
      end
      MD_RING: begin
        if (!ch_enable[m_id]) mode = MD_IDLE;
        else if (btn_dismiss) mode = MD_GAME;
        else if (btn_snooze && m_used < MAXS) begin_snooze();
        else if (sec_tick) begin
          m_elapsed++;
          if (m_elapsed == TMO) begin
            if (m_used < MAXS) begin_snooze();
            else begin
              mode = MD_IDLE;
              nmissed[m_id] = 1'b1;
            end
          end
        end
      end
      MD_SNOOZE: begin
        if (!ch_enable[m_id]) mode = MD_IDLE;
        else if (btn_dismiss) mode = MD_GAME;
        else if (sec_tick) begin
          m_left--;
          if (m_left == 0) begin
            mode = MD_RING;
            m_elapsed = 0;
          end
        end
      end
      default: if (minigame_done) mode = MD_IDLE;
    endcase
    m_pending = (m_pending | (now_match & ~m_prev)) & ch_enable & ~served;
    m_missed  = nmissed;
    m_prev    = now_match;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      chk("m_ringing", 32'(alarm_ringing), 32'(mode == MD_RING));
      chk("m_snoozing", 32'(snoozing), 32'(mode == MD_SNOOZE));
      chk("m_game", 32'(minigame_enable), 32'(mode == MD_GAME));
      chk("m_pending", 32'(pending), 32'(m_pending));
      chk("m_missed", 32'(missed), 32'(m_missed));
      if (mode != MD_IDLE) chk("m_ring_id", 32'(ring_id), 32'(m_id));
      if (rst_n) model_advance();
    end
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, " ringing"}, 32'(alarm_ringing), 0);
    chk({tag, " snoozing"}, 32'(snoozing), 0);
    chk({tag, " game"}, 32'(minigame_enable), 0);
    chk({tag, " ring_id"}, 32'(ring_id), 0);
    chk({tag, " pending"}, 32'(pending), 0);
    chk({tag, " missed"}, 32'(missed), 0);
  endtask

  task automatic pulse_dismiss_done();
    btn_dismiss = 1'b1; step(); btn_dismiss = 1'b0;
    chk("dd game", 32'(minigame_enable), 1);
    minigame_done = 1'b1; step(); minigame_done = 1'b0;
    chk("dd idle", 32'(minigame_enable), 0);
  endtask

  initial begin
    // Reset held with ch0 already matching; release must not fire it.
    step(3); #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    step(3);
    chk("release nofire pending", 32'(pending), 0);
    chk("release nofire ring", 32'(alarm_ringing), 0);

    // Single channel fire, dismiss, minigame completion.
    cur_time = 16'h0010;
    step();
    chk("t1 pending", 32'(pending), 32'b0010);
    chk("t1 not yet ringing", 32'(alarm_ringing), 0);
    step();
    chk("t1 ringing", 32'(alarm_ringing), 1);
    chk("t1 ring_id", 32'(ring_id), 1);
    chk("t1 pending served", 32'(pending), 0);
    btn_dismiss = 1'b1; step(); btn_dismiss = 1'b0;
    chk("t1 game", 32'(minigame_enable), 1);
    chk("t1 ring off", 32'(alarm_ringing), 0);
    minigame_done = 1'b1; step(); minigame_done = 1'b0;
    chk("t1 game off", 32'(minigame_enable), 0);

    // Simultaneous ch0/ch2: lowest index served first.
    alarm_time[15:0] = 16'h0020;
    cur_time = 16'h0020;
    step();
    chk("t2 pending both", 32'(pending), 32'b0101);
    step();
    chk("t2 ring ch0", 32'(ring_id), 0);
    chk("t2 pending ch2", 32'(pending), 32'b0100);
    btn_dismiss = 1'b1; step(); btn_dismiss = 1'b0;
    minigame_done = 1'b1; step(); minigame_done = 1'b0;
    chk("t2 idle gap", 32'(alarm_ringing), 0);
    step();
    chk("t2 ring ch2", 32'(alarm_ringing), 1);
    chk("t2 ring_id 2", 32'(ring_id), 2);

    // Snooze lasts exactly SNZ ticks; snooze beyond MAXS is ignored.
    btn_snooze = 1'b1; step(); btn_snooze = 1'b0;
    chk("t3 snoozing", 32'(snoozing), 1);
    for (int t = 1; t <= SNZ; t++) begin
      sec_tick = 1'b1; step(); sec_tick = 1'b0; step(2);
      if (t == SNZ - 1) chk("t3 still snoozing", 32'(snoozing), 1);
    end
    chk("t3 ring again", 32'(alarm_ringing), 1);
    repeat (MAXS - 1) begin
      btn_snooze = 1'b1; step(); btn_snooze = 1'b0;
      repeat (SNZ) begin
        sec_tick = 1'b1; step(); sec_tick = 1'b0; step();
      end
    end
    chk("t3 ring after 3rd", 32'(alarm_ringing), 1);
    btn_snooze = 1'b1; step(); btn_snooze = 1'b0;
    chk("t3 4th snooze ignored", 32'(alarm_ringing), 1);
    chk("t3 4th not snoozing", 32'(snoozing), 0);
    pulse_dismiss_done();

    // Unanswered: 4 rings of TMO ticks with 3 auto-snoozes, then missed.
    cur_time = 16'h0059;
    step(2);
    chk("t4 ring ch3", 32'(ring_id), 3);
    sec_tick = 1'b1;
    for (int i = 1; i <= 4 * TMO + 3 * SNZ; i++) begin
      step();
      if (i == TMO - 1) chk("t4 ringing before timeout", 32'(alarm_ringing), 1);
      if (i == TMO) chk("t4 auto snooze", 32'(snoozing), 1);
      if (i == TMO + SNZ) chk("t4 ring 2", 32'(alarm_ringing), 1);
    end
    sec_tick = 1'b0;
    chk("t4 idle", 32'(alarm_ringing), 0);
    chk("t4 missed", 32'(missed), 32'b1000);
    clear_missed = 1'b1; step(); clear_missed = 1'b0;
    chk("t4 cleared", 32'(missed), 0);

    // Disable in RING aborts; disable in GAME does not.
    alarm_time[31:16] = 16'h0100;
    cur_time = 16'h0100;
    step(2);
    chk("t5 ring ch1", 32'(ring_id), 1);
    ch_enable[1] = 1'b0; step();
    chk("t5 aborted", 32'(alarm_ringing), 0);
    chk("t5 no missed", 32'(missed), 0);
    ch_enable[1] = 1'b1;
    step(2);
    chk("t5 refire ring", 32'(alarm_ringing), 1);
    btn_dismiss = 1'b1; step(); btn_dismiss = 1'b0;
    ch_enable[1] = 1'b0; step(3);
    chk("t5 game holds", 32'(minigame_enable), 1);
    cur_time = 16'h0200;
    ch_enable[1] = 1'b1;
    minigame_done = 1'b1; step(); minigame_done = 1'b0;
    chk("t5 game done", 32'(minigame_enable), 0);
    step(2);
    chk("t5 nothing pending", 32'(pending), 0);

    // Asynchronous reset while snoozing with another channel pending.
    cur_time = 16'h0059;
    step(2);
    btn_snooze = 1'b1; step(); btn_snooze = 1'b0;
    chk("t6 snoozing", 32'(snoozing), 1);
    alarm_time[47:32] = 16'h0059;
    step();
    chk("t6 pending ch2", 32'(pending), 32'b0100);
    rst_n = 1'b0; #1;
    chk_all_zero("t6 async rst");
    cur_time = 16'h0020;
    step(2);
    rst_n = 1'b1;
    step(3);
    chk("t6 release nofire", 32'(pending), 0);
    chk("t6 release idle", 32'(alarm_ringing), 0);

    step(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
